// File: rtl/chnl_rx_deframer.sv
// Receive-side command deframer: strips a header word (tag + length) and forwards
// the payload words through a tagged first-word-fall-through FIFO.
module chnl_rx_deframer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_val,
  output logic                            i_rdy,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_val,
  input  logic                            o_rdy,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [DATA_WIDTH-LEN_WIDTH-1:0] o_tag,
  output logic                            o_last,
  output logic [15:0]                     o_frames,
  output logic [15:0]                     o_empty_frames
);

  localparam int TAG_W = DATA_WIDTH - LEN_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = TAG_W + 1 + DATA_WIDTH;

  typedef enum logic {S_HDR, S_PAYLOAD} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [TAG_W-1:0]      r_tag;
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [15:0]           r_frames;
  logic [15:0]           r_empty_frames;

  logic [LEN_WIDTH-1:0]  w_hdr_len;
  logic [TAG_W-1:0]      w_hdr_tag;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_hdr_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_in;
  logic [ENT_W-1:0]      w_rd_entry;

  assign w_hdr_len = i_data[LEN_WIDTH-1:0];
  assign w_hdr_tag = i_data[DATA_WIDTH-1:LEN_WIDTH];

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_last_in = (r_cnt == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:     if (i_val && (w_hdr_len != '0)) w_next = S_PAYLOAD;
      S_PAYLOAD: if (w_push && w_last_in)        w_next = S_HDR;
      default:   w_next = S_HDR;
    endcase
  end

  // Full blocks input even when a pop happens in the same cycle.
  always_comb begin
    i_rdy     = 1'b1;
    w_hdr_acc = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      S_HDR: begin
        i_rdy     = 1'b1;
        w_hdr_acc = i_val;
      end
      S_PAYLOAD: begin
        i_rdy  = !w_full;
        w_push = i_val && !w_full;
      end
      default: begin
        i_rdy     = 1'b1;
        w_hdr_acc = 1'b0;
        w_push    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_tag          <= '0;
      r_empty_frames <= '0;
    end else if (w_hdr_acc) begin
      r_cnt <= w_hdr_len;
      r_tag <= w_hdr_tag;
      if (w_hdr_len == '0) r_empty_frames <= r_empty_frames + 16'd1;
    end else if (w_push) begin
      r_cnt <= r_cnt - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {r_tag, w_last_in, i_data};
  end

  assign w_rd_entry = r_mem[r_rptr[AW-1:0]];
  assign w_pop      = !w_empty && o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_frames <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (w_rd_entry[DATA_WIDTH]) r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign o_val          = !w_empty;
  assign o_data         = w_rd_entry[DATA_WIDTH-1:0];
  assign o_last         = w_rd_entry[DATA_WIDTH];
  assign o_tag          = w_rd_entry[ENT_W-1:DATA_WIDTH+1];
  assign o_frames       = r_frames;
  assign o_empty_frames = r_empty_frames;

endmodule

// File: tb/tb_chnl_rx_deframer.sv
// Bench for chnl_rx_deframer: frame table plus hand-written stall, reset and
// counter-wrap sequences; payload expectations flow through a scoreboard queue.
module tb_chnl_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_val;
  logic        i_rdy;
  logic [31:0] i_data;
  logic        o_val;
  logic        o_rdy = 1'b0;
  logic [31:0] o_data;
  logic [15:0] o_tag;
  logic        o_last;
  logic [15:0] o_frames;
  logic [15:0] o_empty_frames;

  chnl_rx_deframer #(.DATA_WIDTH(32), .LEN_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
    .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data), .o_tag(o_tag), .o_last(o_last),
    .o_frames(o_frames), .o_empty_frames(o_empty_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [15:0] tag;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] tag;
    logic [15:0] len;
    logic [31:0] d0;
    logic [31:0] step;
    int          rdy_mode;
    bit          drain;
    bit          lat_chk;
    logic [15:0] exp_frames;
    logic [15:0] exp_empty;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int   checks = 0;
  int   passes = 0;
  int   rdy_mode = 3;

  bit          hold_vld = 0;
  logic [31:0] h_data;
  logic [15:0] h_tag;
  logic        h_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // 0: always ready, 1: toggle, 2: random, 3: stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       o_rdy = 1'b1;
      1:       o_rdy = !o_rdy;
      2:       o_rdy = 1'($urandom_range(0, 1));
      default: o_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_vld = 0;
    end else begin
      if (hold_vld)
        chk("stall_hold", {o_val, o_data, o_tag, o_last}, {1'b1, h_data, h_tag, h_last});
      if (o_val && o_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got data 0x%0h, want no output", o_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(o_data), 64'(e.data));
          chk("out_tag", 64'(o_tag), 64'(e.tag));
          chk("out_last", 64'(o_last), 64'(e.last));
        end
      end
      hold_vld = o_val && !o_rdy;
      h_data   = o_data;
      h_tag    = o_tag;
      h_last   = o_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input bit pl, input logic [15:0] tg, input bit lst);
    int   n = 0;
    bit   ok = 0;
    exp_t e;
    i_val  = 1'b1;
    i_data = d;
    while (n < 300) begin
      @(negedge clk);
      if (i_rdy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (ok) begin
      if (pl) begin
        e.data = d; e.tag = tg; e.last = lst;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end else begin
      checks++;
      $display("FAIL accept_timeout: got i_rdy=0 for 300 cycles, want accept of 0x%0h", d);
    end
    i_val = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    bit ok = 0;
    while (n < 500) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_val) begin
        ok = 1;
        break;
      end
      n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    logic [31:0] d;
    vt[0] = '{16'h00AB, 16'd3, 32'h11,   32'h11, 0, 1, 1, 16'd1, 16'd0};
    vt[1] = '{16'h0005, 16'd0, 32'h0,    32'h0,  0, 1, 0, 16'd1, 16'd1};
    vt[2] = '{16'h0006, 16'd1, 32'hDEAD, 32'h0,  0, 1, 0, 16'd2, 16'd1};
    vt[3] = '{16'h0001, 16'd2, 32'hA0,   32'h1,  1, 0, 0, 16'd3, 16'd1};
    vt[4] = '{16'h0002, 16'd1, 32'hA2,   32'h1,  1, 1, 0, 16'd4, 16'd1};
    vt[5] = '{16'h1234, 16'd7, 32'h5000, 32'h3,  2, 1, 0, 16'd5, 16'd1};
    vt[6] = '{16'hFFFF, 16'd1, 32'hCAFE, 32'h0,  0, 1, 0, 16'd6, 16'd1};

    rst = 1'b1; i_val = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_oval", 64'(o_val), 64'd0);
    chk("rst_irdy", 64'(i_rdy), 64'd1);
    chk("rst_frames", 64'(o_frames), 64'd0);
    chk("rst_empty", 64'(o_empty_frames), 64'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 7; r++) begin
      rdy_mode = vt[r].rdy_mode;
      send_word({vt[r].tag, vt[r].len}, 0, 16'h0, 0);
      if (vt[r].lat_chk) begin
        @(negedge clk);
        chk("lat_pre_oval", 64'(o_val), 64'd0);
        @(posedge clk); #1;
      end
      for (int i = 0; i < int'(vt[r].len); i++) begin
        d = vt[r].d0 + 32'(i) * vt[r].step;
        send_word(d, 1, vt[r].tag, (i == int'(vt[r].len) - 1));
        if (vt[r].lat_chk && i == 0) begin
          @(negedge clk);
          chk("lat_post_oval", 64'(o_val), 64'd1);
          @(posedge clk); #1;
        end
      end
      if (vt[r].drain) begin
        drain_wait();
        chk($sformatf("frames_v%0d", r), 64'(o_frames), 64'(vt[r].exp_frames));
        chk($sformatf("empty_v%0d", r), 64'(o_empty_frames), 64'(vt[r].exp_empty));
        @(posedge clk); #1;
      end
    end

    // FIFO fills with consumer stalled; input must stall after 16 words.
    rdy_mode = 3;
    @(posedge clk); #1;
    send_word({16'h0003, 16'd20}, 0, 16'h0, 0);
    for (int i = 0; i < 16; i++) send_word(32'h300 + 32'(i), 1, 16'h0003, 0);
    @(negedge clk);
    chk("full_irdy", 64'(i_rdy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_irdy_hold", 64'(i_rdy), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    for (int i = 16; i < 20; i++) send_word(32'h300 + 32'(i), 1, 16'h0003, (i == 19));
    drain_wait();
    chk("full_frames", 64'(o_frames), 64'd7);
    chk("full_empty", 64'(o_empty_frames), 64'd1);
    @(posedge clk); #1;

    // Reset mid-frame abandons buffered payload.
    rdy_mode = 3;
    @(posedge clk); #1;
    send_word({16'h0007, 16'd4}, 0, 16'h0, 0);
    send_word(32'h71, 1, 16'h0007, 0);
    send_word(32'h72, 1, 16'h0007, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_oval", 64'(o_val), 64'd0);
    chk("midrst_frames", 64'(o_frames), 64'd0);
    chk("midrst_empty", 64'(o_empty_frames), 64'd0);
    chk("midrst_irdy", 64'(i_rdy), 64'd1);
    @(posedge clk); #1;
    rdy_mode = 0;
    send_word(32'h0009_0001, 0, 16'h0, 0);
    send_word(32'h99, 1, 16'h0009, 1);
    drain_wait();
    chk("post_rst_frames", 64'(o_frames), 64'd1);
    chk("post_rst_empty", 64'(o_empty_frames), 64'd0);
    @(posedge clk); #1;

    // 65537 zero-length headers wrap the empty-frame counter to 1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_val  = 1'b1;
    i_data = 32'h0;
    repeat (65537) @(posedge clk);
    #1 i_val = 1'b0;
    @(negedge clk);
    chk("wrap_empty", 64'(o_empty_frames), 64'd1);
    chk("wrap_frames", 64'(o_frames), 64'd0);
    chk("wrap_oval", 64'(o_val), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
